// File: rtl/data_memory_initiator.sv
// Requester-side data memory controller for the MEM stage: one load or store at a time,
// waits out write-miss latency on mem_ready, with a write watchdog and saturating counters.
module data_memory_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_is_load,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  load_count,
  output logic [CNT_WIDTH-1:0]  store_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD       = 2'd1;
  localparam logic [1:0] WR_ISSUE = 2'd2;
  localparam logic [1:0] WR_WAIT  = 2'd3;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wr_done;
  logic              wr_abort;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign req_ready = (state == IDLE);

  // mem_ready wins over the watchdog when both land on the same cycle
  assign wr_done  = (state == WR_WAIT) && (mem_ready || (wait_cnt == WAIT_LAST));
  assign wr_abort = wr_done && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_is_load <= 1'b0;
      resp_data    <= '0;
      load_count   <= '0;
      store_count  <= '0;
      err_count    <= '0;
      stall_count  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (state == WR_ISSUE || state == WR_WAIT) begin
        stall_count <= sat_inc(stall_count);
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            if (req_we) begin
              mem_wr_data <= req_wdata;
              mem_wr_en   <= 1'b1;
              wait_cnt    <= '0;
              state       <= WR_ISSUE;
            end else begin
              mem_rd_en <= 1'b1;
              state     <= RD;
            end
          end
        end
        RD: begin
          resp_data    <= mem_rd_data;
          resp_is_load <= 1'b1;
          resp_valid   <= 1'b1;
          mem_rd_en    <= 1'b0;
          load_count   <= sat_inc(load_count);
          state        <= IDLE;
        end
        // mem_ready still shows its idle value here, so it is not looked at
        WR_ISSUE: begin
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wr_done) begin
            mem_wr_en    <= 1'b0;
            resp_valid   <= 1'b1;
            resp_is_load <= 1'b0;
            resp_data    <= '0;
            store_count  <= sat_inc(store_count);
            state        <= IDLE;
            if (wr_abort) begin
              resp_err  <= 1'b1;
              err_count <= sat_inc(err_count);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_initiator.sv
// Bench for data_memory_initiator: directed scenarios plus a randomized load/store stream
// against a delayed-ready memory and a behavioural request/response model.
module tb_data_memory_initiator;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid, resp_is_load, resp_err;
  logic [DW-1:0] resp_data;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_ready = 1'b1;
  logic [CW-1:0] load_count, store_count, err_count, stall_count;

  logic [DW-1:0] mem_array [0:63];
  logic [DW-1:0] ref_mem   [0:63];
  int            resp_delay  = 4;
  bit            never_ready = 1'b0;
  bit            rsp_busy    = 1'b0;
  int            rsp_rem     = 0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_memory_initiator #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_is_load(resp_is_load),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .load_count(load_count), .store_count(store_count),
    .err_count(err_count), .stall_count(stall_count)
  );

  function automatic logic [DW-1:0] seed_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'h5000_0000 + DW'(i) * 32'h0001_0003;
  endfunction

  // Store completes D+3 cycles after accept unless the watchdog fires first.
  function automatic int store_latency(input int d);
    return (d <= TO - 1) ? d + 3 : TO + 2;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Memory: combinational read; ready drops on the first wr_en edge and rises D cycles later.
  assign mem_rd_data = mem_array[mem_addr[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_array[i] <= seed_word(i);
      rsp_busy  <= 1'b0;
      mem_ready <= 1'b1;
    end else if (mem_wr_en !== 1'b1) begin
      rsp_busy  <= 1'b0;
      mem_ready <= 1'b1;
    end else if (!rsp_busy) begin
      rsp_busy  <= 1'b1;
      mem_ready <= 1'b0;
      rsp_rem   <= resp_delay;
      mem_array[mem_addr[7:2]] <= mem_wr_data;
    end else if (!never_ready) begin
      if (rsp_rem == 1) mem_ready <= 1'b1;
      if (rsp_rem > 0) rsp_rem <= rsp_rem - 1;
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int nresp;
    reset = 1'b1; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    vectors++;
    if ({mem_wr_en, mem_rd_en, resp_valid, resp_err, resp_is_load} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: wr=%b rd=%b rv=%b err=%b ld=%b want all 0",
               mem_wr_en, mem_rd_en, resp_valid, resp_err, resp_is_load);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wr_data !== '0 || resp_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wr_data, resp_data);
    end
    vectors++;
    if ({load_count, store_count, err_count, stall_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: %0d %0d %0d %0d want 0", load_count, store_count, err_count, stall_count);
    end
    resp_delay = 4; never_ready = 1'b0;
    issue(1'b1, 32'h40, 32'hCAFE_F00D);
    @(negedge clk);
    vectors++;
    if (mem_wr_en !== 1'b1) begin
      miscompares++; $display("FAIL midstore_active: wr_en=%b want 1", mem_wr_en);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL midstore_reset_wr_en: got %b want 0", mem_wr_en);
    end
    reset = 1'b0;
    nresp = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) nresp++;
    end
    vectors++;
    if (nresp != 0) begin
      miscompares++; $display("FAIL midstore_no_resp: got %0d responses want 0", nresp);
    end
  endtask

  task automatic test_load();
    issue(1'b0, 32'h10, 32'h0);
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'h10 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_issue: rd=%b wr=%b addr=%h rdy=%b want 1 0 10 0", mem_rd_en, mem_wr_en, mem_addr, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_is_load !== 1'b1 || resp_data !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_resp: rv=%b ld=%b data=%h err=%b want 1 1 deadbeef 0", resp_valid, resp_is_load, resp_data, resp_err);
    end
    vectors++;
    if (mem_rd_en !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL load_rd_one_cycle: rd=%b rdy=%b want 0 1", mem_rd_en, req_ready);
    end
    vectors++;
    if (load_count !== CW'(1)) begin
      miscompares++; $display("FAIL load_count: got %0d want 1", load_count);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL load_resp_pulse: rv=%b want 0", resp_valid);
    end
  endtask

  task automatic test_store();
    int wen, at;
    bit stable;
    logic err, isld;
    logic [DW-1:0] rd;
    logic [CW-1:0] sc, stc;
    resp_delay = 4; never_ready = 1'b0;
    issue(1'b1, 32'h20, 32'h1234_5678);
    wen = 0; at = 0; stable = 1'b1; err = 1'bx; isld = 1'bx; rd = 'x; sc = 'x; stc = 'x;
    for (int j = 1; j <= 30 && at == 0; j++) begin
      if (mem_wr_en === 1'b1) begin
        wen++;
        if (mem_addr !== 32'h20 || mem_wr_data !== 32'h1234_5678) stable = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        at = j; err = resp_err; isld = resp_is_load; rd = resp_data; sc = store_count; stc = stall_count;
      end else begin
        @(negedge clk);
      end
    end
    vectors++;
    if (wen != 6 || !stable) begin
      miscompares++; $display("FAIL store_wr_en_window: cycles=%0d stable=%0d want 6 1", wen, stable);
    end
    vectors++;
    if (at != 7) begin
      miscompares++; $display("FAIL store_latency: got %0d want 7", at);
    end
    vectors++;
    if (err !== 1'b0 || isld !== 1'b0 || rd !== '0) begin
      miscompares++; $display("FAIL store_resp: err=%b ld=%b data=%h want 0 0 0", err, isld, rd);
    end
    vectors++;
    if (sc !== CW'(1) || stc !== CW'(6)) begin
      miscompares++; $display("FAIL store_counts: store=%0d stall=%0d want 1 6", sc, stc);
    end
  endtask

  task automatic test_timeout();
    int at, dl;
    logic err, rdy;
    logic [CW-1:0] ec, sc, stc;
    never_ready = 1'b1;
    issue(1'b1, 32'h24, 32'hA5A5_5A5A);
    at = 0; err = 1'bx; rdy = 1'bx; ec = 'x; sc = 'x; stc = 'x;
    for (int j = 1; j <= 40 && at == 0; j++) begin
      if (resp_valid === 1'b1) begin
        at = j; err = resp_err; rdy = req_ready; ec = err_count; sc = store_count; stc = stall_count;
      end else begin
        @(negedge clk);
      end
    end
    never_ready = 1'b0;
    vectors++;
    if (at != TO + 2 || err !== 1'b1 || rdy !== 1'b1) begin
      miscompares++; $display("FAIL timeout_resp: at=%0d err=%b rdy=%b want %0d 1 1", at, err, rdy, TO + 2);
    end
    vectors++;
    if (ec !== CW'(1) || sc !== CW'(2) || stc !== CW'(CMAX)) begin
      miscompares++; $display("FAIL timeout_counts: err=%0d store=%0d stall=%0d want 1 2 %0d", ec, sc, stc, CMAX);
    end
    @(negedge clk);
    vectors++;
    if (resp_err !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL timeout_err_pulse: err=%b rv=%b want 0 0", resp_err, resp_valid);
    end
    for (int k = 0; k < 2; k++) begin
      dl = TO - 1 + k;
      resp_delay = dl;
      issue(1'b1, 32'h28, 32'h0BAD_F00D);
      at = 0; err = 1'bx;
      for (int j = 1; j <= 40 && at == 0; j++) begin
        if (resp_valid === 1'b1) begin
          at = j; err = resp_err;
        end else begin
          @(negedge clk);
        end
      end
      vectors++;
      if (at != store_latency(dl) || err !== 1'(dl >= TO)) begin
        miscompares++;
        $display("FAIL ready_vs_watchdog_d%0d: at=%0d err=%b want %0d %0d", dl, at, err, store_latency(dl), dl >= TO);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      issue(1'b0, {24'h0, 6'($urandom), 2'b00}, 32'h0);
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || load_count !== CW'(sat(i))) begin
        miscompares++; $display("FAIL load_sat_%0d: rv=%b count=%0d want 1 %0d", i, resp_valid, load_count, sat(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          acc_pend, out_v, a_we, o_we, a_err, o_err;
    logic [AW-1:0] a_addr, o_addr;
    logic [DW-1:0] a_data, o_data, a_exp, o_exp;
    logic [5:0]    idx;
    int            a_lat, o_lat, age, d;
    int            accepts, resps, loads, stores, errs, stalls;
    acc_pend = 1'b0; out_v = 1'b0; a_we = 1'b0; o_we = 1'b0; a_err = 1'b0; o_err = 1'b0;
    a_addr = '0; o_addr = '0; a_data = '0; o_data = '0; a_exp = '0; o_exp = '0;
    a_lat = 0; o_lat = 0; age = 0;
    accepts = 0; resps = 0; loads = 0; stores = 0; errs = 0; stalls = 0;
    never_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (acc_pend) begin
        out_v = 1'b1; o_we = a_we; o_addr = a_addr; o_data = a_data; o_exp = a_exp;
        o_lat = a_lat; o_err = a_err; age = 0; acc_pend = 1'b0;
      end
      if (out_v) age++;
      vectors++;
      if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) begin
        miscompares++; $display("FAIL b2b_rd_wr_overlap: cycle %0d both enables high", cyc);
      end
      if (out_v && age == 1) begin
        vectors++;
        if ((o_we ? mem_wr_en : mem_rd_en) !== 1'b1) begin
          miscompares++; $display("FAIL b2b_issue: we=%b rd=%b wr=%b at cycle %0d", o_we, mem_rd_en, mem_wr_en, cyc);
        end
      end
      if (out_v && (mem_rd_en === 1'b1 || mem_wr_en === 1'b1)) begin
        vectors++;
        if (mem_addr !== o_addr || (o_we && mem_wr_data !== o_data)) begin
          miscompares++;
          $display("FAIL b2b_stable: addr=%h wdata=%h want %h %h", mem_addr, mem_wr_data, o_addr, o_data);
        end
      end
      if (resp_valid === 1'b1) begin
        vectors++;
        if (!out_v || age != o_lat || resp_is_load !== !o_we || resp_data !== o_exp || resp_err !== o_err) begin
          miscompares++;
          $display("FAIL b2b_resp: pending=%b age=%0d ld=%b data=%h err=%b want age=%0d ld=%b data=%h err=%b",
                   out_v, age, resp_is_load, resp_data, resp_err, o_lat, !o_we, o_exp, o_err);
        end
        resps++;
        out_v = 1'b0;
      end
      if (cyc < 360) begin
        idx       = 6'($urandom);
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = {24'h0, idx, 2'b00};
        req_wdata = $urandom;
        if (req_ready === 1'b1) begin
          acc_pend = 1'b1; accepts++;
          a_we = req_we; a_addr = req_addr; a_data = req_wdata;
          if (req_we) begin
            d = $urandom_range(1, 20);
            resp_delay = d;
            a_lat = store_latency(d); a_err = 1'(d >= TO); a_exp = '0;
            ref_mem[idx] = req_wdata;
            stores++; stalls += a_lat - 1;
            if (a_err) errs++;
          end else begin
            a_lat = 2; a_err = 1'b0; a_exp = ref_mem[idx];
            loads++;
          end
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    vectors++;
    if (resps != accepts) begin
      miscompares++; $display("FAIL b2b_resp_count: got %0d responses want %0d", resps, accepts);
    end
    vectors++;
    if (load_count !== CW'(sat(loads)) || store_count !== CW'(sat(stores)) ||
        err_count !== CW'(sat(errs)) || stall_count !== CW'(sat(stalls))) begin
      miscompares++;
      $display("FAIL b2b_counters: ld=%0d st=%0d err=%0d stall=%0d want %0d %0d %0d %0d",
               load_count, store_count, err_count, stall_count, sat(loads), sat(stores), sat(errs), sat(stalls));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: bench did not complete within 500000 time units");
    $fatal(1, "time limit");
  end

endmodule
